// File: rtl/flit_out_arb_if.sv
// Flit link bundle between local requesters and the output arbiter.
// master: requester/credit side; slave: arbiter side.
interface flit_out_arb_if #(
  parameter int N  = 4,
  parameter int B  = 4,
  parameter int FW = 59
);
  logic [N-1:0]    req_vld;
  logic [N*FW-1:0] req_flit;
  logic [N-1:0]    req_ack;
  logic [FW-1:0]   flit_out;
  logic            flit_out_wr;
  logic            credit_in;
  logic [B:0]      credit_cnt;
  logic            locked;
  logic            credit_err;

  modport master (
    output req_vld, req_flit, credit_in,
    input  req_ack, flit_out, flit_out_wr,
    input  credit_cnt, locked, credit_err
  );

  modport slave (
    input  req_vld, req_flit, credit_in,
    output req_ack, flit_out, flit_out_wr,
    output credit_cnt, locked, credit_err
  );
endinterface

// File: rtl/flit_out_arb.sv
// Credit-based round-robin arbiter for one outgoing flit link.
// Ports: clk, rst_n, bus (slave: req_vld/req_flit/req_ack, flit_out/_wr, credits, lock).
module flit_out_arb #(
  parameter int N   = 4,
  parameter int B   = 4,
  parameter int FW  = 59,
  parameter int FTW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  flit_out_arb_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [B:0] MAXC = (B+1)'(1 << B);
  localparam logic [FTW-1:0] T_DATA = FTW'(1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [B:0]      cnt;
  logic            err;
  logic [FW-1:0]   fo;
  logic            fo_wr;

  logic [N-1:0]    elig;
  logic            pick_vld;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   j;
  logic            grant;
  logic [FW-1:0]   gflit;
  logic            is_data;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] g);
    return (32'(g) == N-1) ? '0 : g + IW'(1);
  endfunction

  always_comb begin
    elig = bus.req_vld;
    if (state == LOCKED)
      elig = bus.req_vld & (N'(1) << owner);
  end

  // Scan from lowest priority to highest so the
  // first eligible slot after ptr wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    j        = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = IW'((32'(ptr) + k) % N);
      if (elig[j]) begin
        pick_vld = 1'b1;
        pick     = j;
      end
    end
  end

  assign grant   = rst_n && pick_vld && (cnt != '0);
  assign gflit   = bus.req_flit[pick*FW +: FW];
  assign is_data = gflit[FW-1 -: FTW] == T_DATA;

  assign bus.req_ack = grant ? (N'(1) << pick) : '0;

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    if (grant) begin
      unique case (state)
        UNLOCKED: begin
          if (is_data) begin
            state_n = LOCKED;
            owner_n = pick;
          end else begin
            ptr_n = inc(pick);
          end
        end
        LOCKED: begin
          if (!is_data) begin
            state_n = UNLOCKED;
            ptr_n   = inc(owner);
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= MAXC;
      err <= 1'b0;
    end else begin
      unique case ({grant, bus.credit_in})
        2'b10: cnt <= cnt - 1'b1;
        2'b01: begin
          if (cnt == MAXC) err <= 1'b1;
          else             cnt <= cnt + 1'b1;
        end
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fo    <= '0;
      fo_wr <= 1'b0;
    end else begin
      fo_wr <= grant;
      if (grant) fo <= gflit;
    end
  end

  assign bus.flit_out    = fo;
  assign bus.flit_out_wr = fo_wr;
  assign bus.credit_cnt  = cnt;
  assign bus.locked      = (state == LOCKED);
  assign bus.credit_err  = err;

endmodule
